qclock_kw11p: RTL and testbench

- Programmable real-time clock (KW11-P register model) on the FPGA internal I/O bus, downstream of the QBUS synchronous interface.
- Consumes the latched address/control and the iWRITE strobe; returns iADDR_MATCH and iRDATA.
- Runs a 16-bit counter from selectable tick sources and raises a level interrupt request to the interrupt multiplexer.

---
 rtl/qclock_kw11p_pkg.sv | 40 ++++
 rtl/qclock_kw11p_if.sv | 11 +
 rtl/qclock_kw11p_timebase.sv | 58 +++++
 rtl/qclock_kw11p.sv | 103 ++++++++++
 tb/tb_qclock_kw11p.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/qclock_kw11p_pkg.sv
// qclock_kw11p_pkg: KW11-P register offsets, CSR bit positions, rate codes and CSR image helper
package qclock_kw11p_pkg;
    localparam logic [12:0] OFF_CSR = 13'd0;
    localparam logic [12:0] OFF_CSB = 13'd2;
    localparam logic [12:0] OFF_CTR = 13'd4;
    localparam int CSR_ERR  = 15;
    localparam int CSR_DONE = 7;
    localparam int CSR_IE   = 6;
    localparam int CSR_FIX  = 5;
    localparam int CSR_UP   = 4;
    localparam int CSR_MODE = 3;
    localparam int CSR_RUN  = 0;
    typedef enum logic [1:0] {
        RATE_100K = 2'b00,
        RATE_10K  = 2'b01,
        RATE_LTC  = 2'b10,
        RATE_EXT  = 2'b11
    } rate_e;
    typedef struct packed {
        logic  err;
        logic  done;
        logic  ie;
        logic  up;
        logic  mode;
        rate_e rate;
        logic  run;
    } csr_t;
    function automatic logic [15:0] csr_image(input csr_t c);
        logic [15:0] v;
        v = '0;
        v[CSR_ERR]  = c.err;
        v[CSR_DONE] = c.done;
        v[CSR_IE]   = c.ie;
        v[CSR_UP]   = c.up;
        v[CSR_MODE] = c.mode;
        v[2:1]      = c.rate;
        v[CSR_RUN]  = c.run;
        return v;
    endfunction
endpackage

// File: rtl/qclock_kw11p_if.sv
// qclock_kw11p_if: internal I/O bus between the QBUS interface (master) and the clock (slave)
interface qclock_kw11p_if;
    logic [12:0] iADDR;
    logic        iBS7;
    logic        iADDR_MATCH;
    logic [15:0] iRDATA;
    logic [15:0] iWDATA;
    logic        iWRITE;
    modport master (output iADDR, iBS7, iWDATA, iWRITE, input iADDR_MATCH, iRDATA);
    modport slave  (input iADDR, iBS7, iWDATA, iWRITE, output iADDR_MATCH, iRDATA);
endinterface

// File: rtl/qclock_kw11p_timebase.sv
// qclock_kw11p_timebase: 100 kHz / 10 kHz prescalers and ltc/ext edge ticks, muxed by RATE
module qclock_kw11p_timebase
    import qclock_kw11p_pkg::*;
#(
    parameter int CLK_HZ = 50_000_000
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  clr,
    input  rate_e rate,
    input  logic  ltc_in,
    input  logic  ext_in,
    output logic  tick
);
    localparam int DIV = CLK_HZ / 100_000;
    localparam int W   = $clog2(DIV);

    logic [W-1:0] pre;
    logic [3:0]   dec;
    logic [2:0]   ltc_s;
    logic [2:0]   ext_s;
    logic         t100;
    logic         t10;
    logic         ltc_edge;
    logic         ext_edge;

    always_comb begin
        t100     = pre == W'(DIV - 1);
        t10      = t100 && dec == 4'd9;
        ltc_edge = ltc_s[1] & ~ltc_s[2];
        ext_edge = ext_s[1] & ~ext_s[2];
        tick     = rate == RATE_100K ? t100 :
                   rate == RATE_10K  ? t10  :
                   rate == RATE_LTC  ? ltc_edge : ext_edge;
    end

    // clr restarts both stages so the next tick comes a full period later
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            pre <= '0;
            dec <= '0;
        end else begin
            pre <= t100 ? '0 : pre + 1'b1;
            if (t100)
                dec <= t10 ? 4'd0 : dec + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ltc_s <= '0;
            ext_s <= '0;
        end else begin
            ltc_s <= {ltc_s[1:0], ltc_in};
            ext_s <= {ext_s[1:0], ext_in};
        end
    end
endmodule

// File: rtl/qclock_kw11p.sv
// qclock_kw11p: KW11-P programmable real-time clock with CSR/CSB/CTR registers and level irq
module qclock_kw11p
    import qclock_kw11p_pkg::*;
#(
    parameter logic [12:0] BASE_ADDR = 13'o12540,
    parameter int          CLK_HZ    = 50_000_000
) (
    input  logic                clk,
    input  logic                reset,
    qclock_kw11p_if.slave       bus,
    input  logic                ltc_in,
    input  logic                ext_in,
    output logic                irq,
    input  logic                irq_ack
);
    localparam logic [12:0] A_CSR = BASE_ADDR + OFF_CSR;
    localparam logic [12:0] A_CSB = BASE_ADDR + OFF_CSB;
    localparam logic [12:0] A_CTR = BASE_ADDR + OFF_CTR;

    csr_t        csr;
    logic [15:0] csb;
    logic [15:0] ctr;
    logic [15:0] ctr_step;
    logic        fix_pend;
    logic        tick;
    logic        hit_csr;
    logic        hit_csb;
    logic        hit_ctr;
    logic        wr_csr;
    logic        wr_csb;
    logic        wr_any;
    logic        prescale_clr;
    logic        step;
    logic        evt;
    logic        unused_ok;

    assign unused_ok = bus.iADDR[0];

    always_comb begin
        hit_csr      = bus.iBS7 && bus.iADDR[12:1] == A_CSR[12:1];
        hit_csb      = bus.iBS7 && bus.iADDR[12:1] == A_CSB[12:1];
        hit_ctr      = bus.iBS7 && bus.iADDR[12:1] == A_CTR[12:1];
        wr_csr       = bus.iWRITE && hit_csr;
        wr_csb       = bus.iWRITE && hit_csb;
        wr_any       = bus.iWRITE && (hit_csr || hit_csb || hit_ctr);
        prescale_clr = wr_csr && bus.iWDATA[CSR_RUN] && !csr.run;
        // a bus write on the same clock swallows any pending tick
        step         = !wr_any && ((tick && csr.run) || fix_pend);
        ctr_step     = csr.up ? ctr + 16'd1 : ctr - 16'd1;
        evt          = step && ctr_step == 16'd0;
    end

    assign bus.iADDR_MATCH = hit_csr | hit_csb | hit_ctr;

    qclock_kw11p_timebase #(.CLK_HZ(CLK_HZ)) u_timebase (
        .clk    (clk),
        .reset  (reset),
        .clr    (prescale_clr),
        .rate   (csr.rate),
        .ltc_in (ltc_in),
        .ext_in (ext_in),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            csr        <= '0;
            csb        <= '0;
            ctr        <= '0;
            fix_pend   <= 1'b0;
            irq        <= 1'b0;
            bus.iRDATA <= '0;
        end else begin
            if (wr_csr) begin
                csr.ie   <= bus.iWDATA[CSR_IE];
                csr.up   <= bus.iWDATA[CSR_UP];
                csr.mode <= bus.iWDATA[CSR_MODE];
                csr.rate <= rate_e'(bus.iWDATA[2:1]);
                csr.run  <= bus.iWDATA[CSR_RUN];
                csr.done <= 1'b0;
                csr.err  <= 1'b0;
            end
            if (wr_csb) begin
                csb <= bus.iWDATA;
                ctr <= bus.iWDATA;
            end
            if (irq_ack && !evt)
                csr.done <= 1'b0;
            if (step) begin
                ctr <= evt && csr.mode ? csb : ctr_step;
                if (evt) begin
                    csr.err  <= csr.err | (csr.done & ~irq_ack);
                    csr.done <= 1'b1;
                    if (!csr.mode)
                        csr.run <= 1'b0;
                end
            end
            fix_pend   <= wr_csr && bus.iWDATA[CSR_FIX] && !bus.iWDATA[CSR_RUN];
            irq        <= csr.done & csr.ie;
            bus.iRDATA <= hit_csr ? csr_image(csr) : hit_ctr ? ctr : 16'd0;
        end
    end
endmodule

// File: tb/tb_qclock_kw11p.sv
// tb_qclock_kw11p: directed self-checking bench for the KW11-P clock at CLK_HZ = 1 MHz
module tb_qclock_kw11p;
    localparam logic [12:0] A_CSR = 13'o12540;
    localparam logic [12:0] A_CSB = 13'o12542;
    localparam logic [12:0] A_CTR = 13'o12544;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ltc_in = 1'b0;
    logic ext_in = 1'b0;
    logic irq_ack = 1'b0;
    logic irq;
    int   checks = 0;
    int   failures = 0;

    qclock_kw11p_if bus();

    qclock_kw11p #(.BASE_ADDR(13'o12540), .CLK_HZ(1_000_000)) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .ltc_in  (ltc_in),
        .ext_in  (ext_in),
        .irq     (irq),
        .irq_ack (irq_ack)
    );

    always #5 clk = ~clk;

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [12:0] a, input logic [15:0] d);
        bus.iADDR  = a;
        bus.iBS7   = 1'b1;
        bus.iWDATA = d;
        bus.iWRITE = 1'b1;
        idle(1);
        bus.iWRITE = 1'b0;
    endtask

    task automatic test_reset;
        logic [12:0] addrs [7];
        logic        bs    [7];
        logic        exp   [7];
        addrs = '{13'o12540, 13'o12542, 13'o12544, 13'o12546, 13'o12541, 13'o12545, 13'o12540};
        bs    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        exp   = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
        bus.iADDR  = 13'd0;
        bus.iBS7   = 1'b0;
        bus.iWDATA = 16'd0;
        bus.iWRITE = 1'b0;
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL reset_irq got=%b exp=0", irq);
        end
        for (int i = 0; i < 3; i++) begin
            bus.iADDR = A_CSR + 13'(2 * i);
            bus.iBS7  = 1'b1;
            idle(1);
            checks++;
            if (bus.iRDATA !== 16'd0) begin
                failures++;
                $display("FAIL reset_read%0d got=%h exp=0000", i, bus.iRDATA);
            end
        end
        for (int i = 0; i < 7; i++) begin
            bus.iADDR = addrs[i];
            bus.iBS7  = bs[i];
            #1;
            checks++;
            if (bus.iADDR_MATCH !== exp[i]) begin
                failures++;
                $display("FAIL match_%0o_bs%0b got=%b exp=%b", addrs[i], bs[i], bus.iADDR_MATCH, exp[i]);
            end
        end
        bus.iBS7 = 1'b1;
        idle(1);
    endtask

    task automatic test_oneshot;
        wr(A_CSB, 16'd3);
        wr(A_CSR, 16'o101);
        bus.iADDR = A_CTR;
        idle(10);
        checks++;
        if (bus.iRDATA !== 16'd3) begin
            failures++;
            $display("FAIL oneshot_ctr_before got=%h exp=0003", bus.iRDATA);
        end
        idle(1);
        checks++;
        if (bus.iRDATA !== 16'd2) begin
            failures++;
            $display("FAIL oneshot_ctr2 got=%h exp=0002", bus.iRDATA);
        end
        idle(10);
        checks++;
        if (bus.iRDATA !== 16'd1) begin
            failures++;
            $display("FAIL oneshot_ctr1 got=%h exp=0001", bus.iRDATA);
        end
        idle(9);
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL oneshot_irq_early got=%b exp=0", irq);
        end
        idle(1);
        checks++;
        if (bus.iRDATA !== 16'd0 || irq !== 1'b1) begin
            failures++;
            $display("FAIL oneshot_done ctr=%h irq=%b exp ctr=0000 irq=1", bus.iRDATA, irq);
        end
        bus.iADDR = A_CSR;
        idle(1);
        checks++;
        if (bus.iRDATA !== 16'o300) begin
            failures++;
            $display("FAIL oneshot_csr got=%o exp=300", bus.iRDATA);
        end
        irq_ack = 1'b1;
        idle(1);
        irq_ack = 1'b0;
        idle(1);
        checks++;
        if (irq !== 1'b0 || bus.iRDATA !== 16'o100) begin
            failures++;
            $display("FAIL oneshot_ack irq=%b csr=%o exp irq=0 csr=100", irq, bus.iRDATA);
        end
    endtask

    task automatic test_repeat;
        wr(A_CSB, 16'd2);
        wr(A_CSR, 16'o111);
        bus.iADDR = A_CTR;
        idle(20);
        checks++;
        if (bus.iRDATA !== 16'd1) begin
            failures++;
            $display("FAIL repeat_pre got=%h exp=0001", bus.iRDATA);
        end
        idle(1);
        checks++;
        if (bus.iRDATA !== 16'd2) begin
            failures++;
            $display("FAIL repeat_reload got=%h exp=0002", bus.iRDATA);
        end
        bus.iADDR = A_CSR;
        idle(20);
        checks++;
        if (bus.iRDATA !== 16'o100311) begin
            failures++;
            $display("FAIL repeat_err_csr got=%o exp=100311", bus.iRDATA);
        end
        wr(A_CSR, 16'o000);
        idle(1);
        checks++;
        if (bus.iRDATA !== 16'd0) begin
            failures++;
            $display("FAIL repeat_clear got=%o exp=0", bus.iRDATA);
        end
    endtask

    task automatic test_up;
        wr(A_CSB, 16'hFFFE);
        wr(A_CSR, 16'o021);
        bus.iADDR = A_CTR;
        idle(11);
        checks++;
        if (bus.iRDATA !== 16'hFFFF) begin
            failures++;
            $display("FAIL up_ffff got=%h exp=ffff", bus.iRDATA);
        end
        idle(10);
        checks++;
        if (bus.iRDATA !== 16'h0000) begin
            failures++;
            $display("FAIL up_wrap got=%h exp=0000", bus.iRDATA);
        end
        bus.iADDR = A_CSR;
        idle(1);
        checks++;
        if (bus.iRDATA !== 16'o220) begin
            failures++;
            $display("FAIL up_csr got=%o exp=220", bus.iRDATA);
        end
        bus.iADDR = A_CTR;
        idle(15);
        checks++;
        if (bus.iRDATA !== 16'h0000) begin
            failures++;
            $display("FAIL up_stopped got=%h exp=0000", bus.iRDATA);
        end
    endtask

    task automatic test_fix;
        wr(A_CSB, 16'd5);
        wr(A_CSR, 16'o040);
        bus.iADDR = A_CTR;
        idle(1);
        checks++;
        if (bus.iRDATA !== 16'd5) begin
            failures++;
            $display("FAIL fix_before got=%h exp=0005", bus.iRDATA);
        end
        idle(1);
        checks++;
        if (bus.iRDATA !== 16'd4) begin
            failures++;
            $display("FAIL fix_step got=%h exp=0004", bus.iRDATA);
        end
        idle(20);
        checks++;
        if (bus.iRDATA !== 16'd4) begin
            failures++;
            $display("FAIL fix_once got=%h exp=0004", bus.iRDATA);
        end
        bus.iADDR = A_CSR;
        idle(1);
        checks++;
        if (bus.iRDATA !== 16'd0) begin
            failures++;
            $display("FAIL fix_csr got=%o exp=0", bus.iRDATA);
        end
    endtask

    task automatic test_ltc;
        wr(A_CSB, 16'd10);
        wr(A_CSR, 16'o005);
        bus.iADDR = A_CTR;
        for (int i = 0; i < 3; i++) begin
            ltc_in = 1'b1;
            idle(3);
            checks++;
            if (bus.iRDATA !== 16'(10 - i)) begin
                failures++;
                $display("FAIL ltc_hold%0d got=%h exp=%h", i, bus.iRDATA, 16'(10 - i));
            end
            idle(1);
            checks++;
            if (bus.iRDATA !== 16'(9 - i)) begin
                failures++;
                $display("FAIL ltc_step%0d got=%h exp=%h", i, bus.iRDATA, 16'(9 - i));
            end
            ltc_in = 1'b0;
            idle(3);
        end
        ltc_in = 1'b1;
        idle(2);
        wr(A_CSB, 16'h0100);
        bus.iADDR = A_CTR;
        idle(1);
        checks++;
        if (bus.iRDATA !== 16'h0100) begin
            failures++;
            $display("FAIL back_to_back_load got=%h exp=0100", bus.iRDATA);
        end
        idle(3);
        checks++;
        if (bus.iRDATA !== 16'h0100) begin
            failures++;
            $display("FAIL back_to_back_nodec got=%h exp=0100", bus.iRDATA);
        end
        ltc_in = 1'b0;
        bus.iADDR = 13'o12546;
        idle(1);
        checks++;
        if (bus.iRDATA !== 16'd0) begin
            failures++;
            $display("FAIL unmatched_read got=%h exp=0000", bus.iRDATA);
        end
    endtask

    initial begin
        test_reset;
        test_oneshot;
        test_repeat;
        test_up;
        test_fix;
        test_ltc;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
